spi_controller: RTL



---
 rtl/spi_pkg.sv | 48 ++++
 rtl/spi_if.sv | 29 ++
 rtl/spi_controller.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write initiator: frame layout,
// controller states and the peripheral register map.
package spi_pkg;

  localparam int FRAME_W  = 16;
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
  localparam int DATA_W   = DATA_MSB + 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } spi_ctrl_state_t;

  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [FRAME_W-1:0] pack_frame(input logic rw,
                                                    input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    logic [FRAME_W-1:0] f;
    f                      = '0;
    f[RW_BIT]              = rw;
    f[ADDR_MSB:ADDR_LSB]   = addr;
    f[DATA_MSB:0]          = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_if.sv
// Request/response handshake plus SPI pins of the initiator.
// master = the controller's view, slave = requester and peripheral side.
interface spi_if;
  import spi_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              sclk;
  logic              ncs;
  logic              copi;
  logic              cipo;

  modport master (
    input  req_valid, req_rw, req_addr, req_data, cipo,
    output req_ready, rsp_valid, rsp_data, busy, sclk, ncs, copi
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_data, cipo,
    input  req_ready, rsp_valid, rsp_data, busy, sclk, ncs, copi
  );

endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: sends one 16-bit R/W+address+data frame per request
// and returns the CIPO byte captured during the data half of the frame.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input logic   clk,
  input logic   rst,
  spi_if.master bus
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be at least 2");
  end
  if (CS_SETUP < 1) begin : g_bad_cs_setup
    $error("spi_controller: CS_SETUP must be at least 1");
  end
  if (CS_HOLD < 1) begin : g_bad_cs_hold
    $error("spi_controller: CS_HOLD must be at least 1");
  end
  if (CS_GAP < 1) begin : g_bad_cs_gap
    $error("spi_controller: CS_GAP must be at least 1");
  end

  // After the 16th falling edge sclk stays low for one more half-period
  // before the hold window, so the frame spans 32 half-periods.
  localparam int HOLD_CYC = CLK_DIV + CS_HOLD;
  localparam int CNT_W    = $clog2(max4(CLK_DIV, CS_SETUP, HOLD_CYC, CS_GAP));

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t SETUP_END = cnt_t'(CS_SETUP - 1);
  localparam cnt_t DIV_END   = cnt_t'(CLK_DIV - 1);
  localparam cnt_t HOLD_END  = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t GAP_END   = cnt_t'(CS_GAP - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

  spi_ctrl_state_t    state_q, state_d;
  cnt_t               cnt_q, cnt_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic               sclk_q, sclk_d;
  logic               ncs_q, ncs_d;
  logic               copi_q, copi_d;
  logic               busy_q, busy_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               cipo_meta, cipo_sync;

  // cipo arrives from another clock domain; two flops before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cipo_meta <= 1'b0;
      cipo_sync <= 1'b0;
    end else begin
      cipo_meta <= bus.cipo;
      cipo_sync <= cipo_meta;
    end
  end

  // NOTE: every flop is written with <= so all registers update together
  // from the values present before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_q        <= '0;
      sclk_q      <= 1'b0;
      ncs_q       <= 1'b1;
      copi_q      <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      sclk_q      <= sclk_d;
      ncs_q       <= ncs_d;
      copi_q      <= copi_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // NOTE: each variable gets a default before the case statement so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + cnt_t'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    sclk_d      = sclk_q;
    ncs_d       = ncs_q;
    copi_d      = copi_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          shift_d   = pack_frame(bus.req_rw, bus.req_addr, bus.req_data);
          bit_cnt_d = '0;
          ncs_d     = 1'b0;
          sclk_d    = 1'b0;
          copi_d    = bus.req_rw;
          busy_d    = 1'b1;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_END) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end
      end

      SHIFT_HI: begin
        if (cnt_q == DIV_END) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          rx_d   = {rx_q[DATA_W-2:0], cipo_sync};
          if (bit_cnt_q == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            // Next bit goes out on the falling edge, a full half-period ahead.
            shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
            copi_d    = shift_q[FRAME_W-2];
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = SHIFT_LO;
          end
        end
      end

      SHIFT_LO: begin
        if (cnt_q == DIV_END) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end
      end

      HOLD: begin
        if (cnt_q == HOLD_END) begin
          cnt_d       = '0;
          ncs_d       = 1'b1;
          copi_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
          state_d     = GAP;
        end
      end

      GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        ncs_d   = 1'b1;
        sclk_d  = 1'b0;
        copi_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.sclk      = sclk_q;
  assign bus.ncs       = ncs_q;
  assign bus.copi      = copi_q;

endmodule
